// File: rtl/ysyx_22040237_ifu.sv
// Instruction fetch unit: owns the fetch PC, issues one outstanding 32-bit fetch at a time,
// and buffers {pc, inst} pairs in a small FIFO toward decode. Redirects flush and restart fetch.
module ysyx_22040237_ifu #(
    parameter logic [63:0] RESET_PC   = 64'h8000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

    state_t            state_reg;
    logic [63:0]       fetch_pc_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [PTR_W-1:0]  head_reg;
    logic [PTR_W-1:0]  tail_reg;
    logic [63:0]       pc_mem   [FIFO_DEPTH];
    logic [31:0]       inst_mem [FIFO_DEPTH];

    logic              req_fire;
    logic              push;
    logic              pop;
    logic [CNT_W-1:0]  count_after_push;
    logic [63:0]       redirect_pc_aligned;

    assign imem_req_valid      = (state_reg == REQ) & ~rst;
    assign imem_req_addr       = fetch_pc_reg;
    assign req_fire            = imem_req_valid & imem_req_ready;
    assign redirect_pc_aligned = redirect_pc & ~64'd3;

    // A redirect cancels both the push of an in-flight response and any pop this cycle.
    assign push = (state_reg == WAIT) & imem_rsp_valid & ~redirect_valid & ~rst;
    assign pop  = inst_valid & inst_ready & ~redirect_valid;

    assign count_after_push = count_reg + CNT_W'(1) - CNT_W'(pop);

    assign inst_valid = (count_reg != '0) & ~rst;
    assign inst       = inst_valid ? inst_mem[head_reg] : 32'h0;
    assign inst_pc    = inst_valid ? pc_mem[head_reg]   : 64'h0;

    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[tail_reg]   <= fetch_pc_reg;
            inst_mem[tail_reg] <= imem_rsp_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= REQ;
            fetch_pc_reg <= RESET_PC;
            count_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
        end else if (redirect_valid) begin
            fetch_pc_reg <= redirect_pc_aligned;
            count_reg    <= '0;
            head_reg     <= '0;
            tail_reg     <= '0;
            // Anything already handed to memory must be drained through DROP.
            case (state_reg)
                IDLE:    state_reg <= REQ;
                REQ:     state_reg <= req_fire ? DROP : REQ;
                WAIT:    state_reg <= imem_rsp_valid ? REQ : DROP;
                DROP:    state_reg <= imem_rsp_valid ? REQ : DROP;
                default: state_reg <= REQ;
            endcase
        end else begin
            if (push) begin
                tail_reg <= tail_reg + PTR_W'(1);
            end
            if (pop) begin
                head_reg <= head_reg + PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - CNT_W'(1);
            end

            case (state_reg)
                IDLE: begin
                    if (count_reg < DEPTH_C) begin
                        state_reg <= REQ;
                    end
                end
                REQ: begin
                    if (imem_req_ready) begin
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        fetch_pc_reg <= fetch_pc_reg + 64'd4;
                        state_reg    <= (count_after_push < DEPTH_C) ? REQ : IDLE;
                    end
                end
                DROP: begin
                    if (imem_rsp_valid) begin
                        state_reg <= REQ;
                    end
                end
                default: state_reg <= REQ;
            endcase
        end
    end
endmodule

// File: doc/ysyx_22040237_ifu.md
Name: ysyx_22040237_ifu

Overview:
Instruction fetch unit directly upstream of the decode stage. It owns the fetch PC and issues one-at-a-time 32-bit fetch requests to instruction memory over a valid/ready request channel and a valid-only response channel. Fetched instructions are buffered with their PC in a small FIFO. The FIFO head is presented to decode with an inst_valid/inst_ready handshake. A redirect port lets execute flush the FIFO and restart fetch at a new PC.

Parameters:
RESET_PC, 64'h8000_0000, first fetch address after reset
FIFO_DEPTH, 2, number of {pc, inst} entries buffered toward decode (power of 2, >=2)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request this cycle
imem_req_addr  out  64  fetch address, bits [1:0] always 0
imem_rsp_valid  in  1  response data valid, at earliest 1 cycle after the accepting cycle
imem_rsp_data  in  32  fetched instruction word
inst_valid  out  1  FIFO head valid toward decode
inst_ready  in  1  decode consumes head this cycle
inst  out  32  instruction at FIFO head, 32'h0 when empty
inst_pc  out  64  PC of FIFO head, 64'h0 when empty
redirect_valid  in  1  flush and restart fetch
redirect_pc  in  64  new fetch PC, bits [1:0] forced to 0

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, FIFO empty, state=REQ. While rst=1: imem_req_valid=0, inst_valid=0, inst=0, inst_pc=0.
- FSM states: IDLE, REQ, WAIT, DROP.
- imem_req_valid = (state==REQ) & ~rst. imem_req_addr = fetch_pc in every state.
- IDLE: go to REQ when count<FIFO_DEPTH, using registered count.
- REQ: if imem_req_ready, go to WAIT. Otherwise hold valid with a stable address. The address may change only through a redirect.
- WAIT: on imem_rsp_valid, push {fetch_pc, imem_rsp_data} and set fetch_pc+=4 (64-bit wrap). Next state is REQ if count_after_push<FIFO_DEPTH, else IDLE.
- DROP: on imem_rsp_valid, discard the data and go to REQ. fetch_pc is unchanged.
- Outstanding requests are limited to one. A request is issued only when count<FIFO_DEPTH, so a push never meets a full FIFO.
- Decode side: inst_valid = count!=0 & ~rst. inst and inst_pc come combinationally from the registered head entry. A pop occurs when inst_valid & inst_ready.
- Push and pop in the same cycle: both happen and count is unchanged.
- Head/tail pointers wrap modulo FIFO_DEPTH.
- Redirect (redirect_valid=1, highest priority after rst):
  - In all states: FIFO flushed (count=0), fetch_pc={redirect_pc[63:2],2'b00}. Any pop that cycle is ignored.
  - IDLE or REQ without a request handshake: next state REQ.
  - REQ with a request handshake that same cycle: next state DROP.
  - WAIT without imem_rsp_valid: next state DROP.
  - WAIT with imem_rsp_valid: response discarded, next state REQ.
  - DROP: state stays DROP. A response arriving that same cycle is discarded and the next state is REQ.
- imem_rsp_valid in IDLE or REQ is a protocol violation and is ignored. No state change.
- Minimum latency: request accepted at cycle N, response at N+1, inst_valid at N+2. Sustained throughput is one instruction per 2 cycles with a 1-cycle memory.
- Reset mid-operation: any outstanding response after reset is not expected. Memory is reset together with the IFU.

Test Plan:
- Reset release, memory always ready, 1-cycle response, inst_ready=1 -> requests at 0x80000000, 0x80000004, 0x80000008. inst_valid first high 2 cycles after the first request is accepted, with inst_pc=0x80000000 and inst = returned word.
- inst_ready=0 with FIFO_DEPTH=2 -> exactly 2 entries fill, then imem_req_valid drops (IDLE). Raising inst_ready for 1 cycle -> pop 0x80000000, a new request at 0x80000008 follows.
- imem_req_ready low for 3 cycles -> imem_req_valid and imem_req_addr=0x80000000 held stable throughout. Handshake on the 4th cycle.
- Redirect to 0x80001002 while in WAIT, response arrives 2 cycles later -> FIFO empty, response dropped. Next request address is 0x80001000, and the first inst_pc out is 0x80001000.
- Redirect in the same cycle as imem_rsp_valid and a pop -> nothing pushed, count=0. Next cycle imem_req_valid=1 at the redirect PC.
- rst asserted while FIFO holds 2 entries -> next cycle inst_valid=0, inst=0, inst_pc=0. After rst deasserts, the first request address is 0x80000000.
